// File: rtl/recv_check_module.sv
// Terminates one switch output port and checks each packet's header, sequence number and payload pattern.
// Each finished packet gives a one-cycle good or bad pulse one cycle after its eop beat.
module recv_check_module #(
  parameter int RX_PORT         = 0,
  parameter int PORT_NUB_TOTAL  = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int PRIORITY        = 8,
  parameter int DATA_LENGTH_MAX = 256,
  localparam int WIDTH_SEL      = $clog2(PORT_NUB_TOTAL),
  localparam int WIDTH_PRIORITY = $clog2(PRIORITY),
  localparam int WIDTH_LENGTH   = $clog2(DATA_LENGTH_MAX)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_sop,
  input  logic                      rd_eop,
  input  logic                      rd_vld,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  input  logic                      ready_en,
  output logic                      ready,
  output logic                      pkt_done,
  output logic                      pkt_err,
  output logic [2:0]                err_code,
  output logic [WIDTH_SEL-1:0]      last_src,
  output logic [WIDTH_PRIORITY-1:0] last_prio,
  output logic [WIDTH_LENGTH-1:0]   last_len,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               err_cnt
);
  localparam int WIDTH_SEQ = 12;
  localparam int OFF_PRIO  = WIDTH_SEL;
  localparam int OFF_LEN   = OFF_PRIO + WIDTH_PRIORITY;
  localparam int OFF_SRC   = OFF_LEN + WIDTH_LENGTH;
  localparam int OFF_SEQ   = OFF_SRC + WIDTH_SEL;

  typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;
  state_t state, state_next;

  logic [WIDTH_SEL-1:0]      h_dest, h_src, src_q;
  logic [WIDTH_PRIORITY-1:0] h_prio, prio_q;
  logic [WIDTH_LENGTH-1:0]   h_len, len_q, cnt_q;
  logic [WIDTH_SEQ-1:0]      h_seq, seq_q;
  logic [WIDTH_SEQ-1:0]      seq_tbl [PORT_NUB_TOTAL];
  logic [2:0]                err_q, new_err, err_eff;
  logic [DATA_WIDTH-1:0]     exp_data;
  logic beat, is_last, cap_hdr, cnt_inc, fin_ok, fin_err, orphan;

  assign beat     = rd_vld & ready;
  assign h_dest   = rd_data[0 +: WIDTH_SEL];
  assign h_prio   = rd_data[OFF_PRIO +: WIDTH_PRIORITY];
  assign h_len    = rd_data[OFF_LEN +: WIDTH_LENGTH];
  assign h_src    = rd_data[OFF_SRC +: WIDTH_SEL];
  assign h_seq    = rd_data[OFF_SEQ +: WIDTH_SEQ];
  assign exp_data = DATA_WIDTH'({src_q, seq_q, 16'(cnt_q)});
  assign is_last  = (cnt_q == len_q - WIDTH_LENGTH'(1));

  always_comb begin
    state_next = state;
    cap_hdr    = 1'b0;
    cnt_inc    = 1'b0;
    fin_ok     = 1'b0;
    fin_err    = 1'b0;
    orphan     = 1'b0;
    new_err    = 3'd0;
    err_eff    = 3'd0;
    // Error candidates are tested lowest code first so same-cycle ties resolve to the smallest code.
    unique case (state)
      IDLE: if (beat) begin
        if (rd_sop) begin
          cap_hdr = 1'b1;
          if (h_dest != WIDTH_SEL'(RX_PORT))            new_err = 3'd1;
          else if (rd_eop && h_len != '0)               new_err = 3'd2;
          else if (h_seq != seq_tbl[h_src])             new_err = 3'd4;
          if (!rd_eop) state_next = PAYLOAD;
        end else begin
          orphan = 1'b1;
        end
      end
      PAYLOAD: if (beat) begin
        if (rd_sop) begin
          new_err    = 3'd5;
          state_next = DRAIN;
        end else begin
          cnt_inc = 1'b1;
          if (rd_eop != is_last)         new_err = 3'd2;
          else if (rd_data != exp_data)  new_err = 3'd3;
          if (rd_eop)       state_next = IDLE;
          else if (is_last) state_next = DRAIN;
        end
      end
      DRAIN: if (beat) begin
        if (rd_sop) new_err = 3'd5;
        if (rd_eop) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    err_eff = (state != IDLE && err_q != 3'd0) ? err_q : new_err;
    if (beat && rd_eop && !(state == PAYLOAD && rd_sop) && !orphan) begin
      fin_ok  = (err_eff == 3'd0);
      fin_err = (err_eff != 3'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PORT_NUB_TOTAL; i++) seq_tbl[i] <= '0;
    end else if (cap_hdr) begin
      seq_tbl[h_src] <= h_seq + WIDTH_SEQ'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready     <= 1'b0;
      pkt_done  <= 1'b0;
      pkt_err   <= 1'b0;
      err_code  <= '0;
      last_src  <= '0;
      last_prio <= '0;
      last_len  <= '0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
      src_q     <= '0;
      prio_q    <= '0;
      len_q     <= '0;
      seq_q     <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
    end else begin
      ready    <= ready_en;
      pkt_done <= fin_ok;
      pkt_err  <= fin_err | orphan;
      if (cap_hdr) begin
        src_q  <= h_src;
        prio_q <= h_prio;
        len_q  <= h_len;
        seq_q  <= h_seq;
        cnt_q  <= '0;
        err_q  <= new_err;
      end else if (beat && state != IDLE) begin
        err_q <= err_eff;
      end
      if (cnt_inc) cnt_q <= cnt_q + WIDTH_LENGTH'(1);
      // A header-only packet finishes from the live header, everything else from the captured one.
      if (fin_ok || fin_err) begin
        last_src  <= (state == IDLE) ? h_src  : src_q;
        last_prio <= (state == IDLE) ? h_prio : prio_q;
        last_len  <= (state == IDLE) ? h_len  : len_q;
      end
      if (fin_err)     err_code <= err_eff;
      else if (orphan) err_code <= 3'd6;
      if (fin_ok && pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
      if ((fin_err || orphan) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_recv_check_module.sv
// Drives packet vectors into recv_check_module and checks every finish pulse against a scoreboard.
module tb_recv_check_module;
  logic        clk = 1'b0, rst = 1'b1;
  logic        rd_sop = 1'b0, rd_eop = 1'b0, rd_vld = 1'b0, ready_en = 1'b1;
  logic [31:0] rd_data = '0;
  logic        ready, pkt_done, pkt_err;
  logic [2:0]  err_code, last_prio;
  logic [3:0]  last_src;
  logic [7:0]  last_len;
  logic [15:0] pkt_cnt, err_cnt;

  recv_check_module dut (
    .clk(clk), .rst(rst), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_vld(rd_vld),
    .rd_data(rd_data), .ready_en(ready_en), .ready(ready), .pkt_done(pkt_done),
    .pkt_err(pkt_err), .err_code(err_code), .last_src(last_src), .last_prio(last_prio),
    .last_len(last_len), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  src, dest;
    logic [2:0]  prio;
    logic [7:0]  len;
    logic [11:0] seq;
    int          nbeats, corrupt, gap;
    logic [2:0]  code;
  } vec_t;

  typedef struct {
    int          cyc;
    bit          done, chk_last;
    logic [2:0]  code, prio;
    logic [3:0]  src;
    logic [7:0]  len;
    logic [15:0] pc, ec;
  } exp_t;

  vec_t vecs[14];
  exp_t q[$];
  exp_t e;
  int n_tests = 0, n_fail = 0, cyc = 0;
  logic [15:0] m_pc = '0, m_ec = '0;
  logic [2:0]  m_code = '0, m_prio = '0;
  logic [3:0]  m_src = '0;
  logic [7:0]  m_len = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic expect_pkt(input bit done, input logic [2:0] code, input logic [3:0] src,
                            input logic [2:0] prio, input logic [7:0] len, input bit chk_last);
    exp_t x;
    if (done) m_pc++;
    else begin m_ec++; m_code = code; end
    if (chk_last) begin m_src = src; m_prio = prio; m_len = len; end
    x.cyc = cyc + 1; x.done = done; x.chk_last = chk_last; x.code = m_code;
    x.src = m_src; x.prio = m_prio; x.len = m_len; x.pc = m_pc; x.ec = m_ec;
    q.push_back(x);
  endtask

  task automatic beat(input bit sop, input bit eop, input logic [31:0] d);
    rd_vld = 1'b1; rd_sop = sop; rd_eop = eop; rd_data = d;
    @(negedge clk);
    rd_vld = 1'b0; rd_sop = 1'b0; rd_eop = 1'b0;
  endtask

  task automatic send_pkt(input vec_t v);
    logic [31:0] d;
    d = {1'b0, v.seq, v.src, v.len, v.prio, v.dest};
    if (v.nbeats == 0) expect_pkt(v.code == 0, v.code, v.src, v.prio, v.len, 1'b1);
    beat(1'b1, v.nbeats == 0, d);
    for (int k = 0; k < v.nbeats; k++) begin
      if (v.gap > 0) repeat ($urandom_range(1, v.gap)) @(negedge clk);
      d = {v.src, v.seq, 16'(k)};
      if (k == v.corrupt) d = d ^ 32'h0000_0100;
      if (k == v.nbeats - 1) expect_pkt(v.code == 0, v.code, v.src, v.prio, v.len, 1'b1);
      beat(1'b0, k == v.nbeats - 1, d);
    end
    @(negedge clk);
  endtask

  // Scoreboard: every finish pulse must land exactly on the cycle recorded at eop time.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      chk("pkt_done", pkt_done, e.done);
      chk("pkt_err", pkt_err, !e.done);
      chk("err_code", err_code, e.code);
      chk("pkt_cnt", pkt_cnt, e.pc);
      chk("err_cnt", err_cnt, e.ec);
      if (e.chk_last) begin
        chk("last_src", last_src, e.src);
        chk("last_prio", last_prio, e.prio);
        chk("last_len", last_len, e.len);
      end
    end else if (pkt_done || pkt_err) begin
      chk("unexpected_pulse", {pkt_done, pkt_err}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // src, dest, prio, len, seq, nbeats, corrupt, gap, code
    vecs[0]  = '{4'd3, 4'd0, 3'd1, 8'd15,  12'd0, 15,  -1, 0, 3'd0};
    vecs[1]  = '{4'd3, 4'd0, 3'd2, 8'd15,  12'd1, 15,  -1, 5, 3'd0};
    vecs[2]  = '{4'd1, 4'd0, 3'd3, 8'd20,  12'd0, 11,  -1, 0, 3'd2};
    vecs[3]  = '{4'd5, 4'd0, 3'd4, 8'd4,   12'd0, 4,   -1, 0, 3'd0};
    vecs[4]  = '{4'd5, 4'd0, 3'd5, 8'd4,   12'd2, 4,   -1, 0, 3'd4};
    vecs[5]  = '{4'd5, 4'd0, 3'd6, 8'd4,   12'd3, 4,   -1, 2, 3'd0};
    vecs[6]  = '{4'd2, 4'd7, 3'd7, 8'd8,   12'd0, 8,    4, 0, 3'd1};
    vecs[7]  = '{4'd0, 4'd0, 3'd0, 8'd0,   12'd0, 0,   -1, 0, 3'd0};
    vecs[8]  = '{4'd0, 4'd0, 3'd1, 8'd1,   12'd1, 1,   -1, 0, 3'd0};
    vecs[9]  = '{4'd6, 4'd0, 3'd2, 8'd6,   12'd0, 6,    0, 0, 3'd3};
    vecs[10] = '{4'd0, 4'd0, 3'd3, 8'd3,   12'd2, 6,   -1, 1, 3'd2};
    vecs[11] = '{4'd7, 4'd0, 3'd4, 8'd3,   12'd0, 0,   -1, 0, 3'd2};
    vecs[12] = '{4'd4, 4'd0, 3'd5, 8'd255, 12'd0, 255, -1, 0, 3'd0};
    vecs[13] = '{4'd8, 4'd3, 3'd6, 8'd2,   12'd5, 0,   -1, 0, 3'd1};

    repeat (2) @(negedge clk);
    chk("rst_ready", ready, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_last", {last_src, last_prio, last_len}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", ready, 1);

    for (int i = 0; i < 14; i++) send_pkt(vecs[i]);

    // ready lags ready_en by one cycle; beats while ready is low are ignored.
    ready_en = 1'b0;
    chk("ready_hold", ready, 1);
    @(negedge clk);
    chk("ready_drop", ready, 0);
    beat(1'b0, 1'b1, 32'hDEAD_BEEF);
    beat(1'b0, 1'b0, 32'h1234_5678);
    ready_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_back", ready, 1);

    expect_pkt(1'b0, 3'd6, 4'd0, 3'd0, 8'd0, 1'b0);
    beat(1'b0, 1'b0, 32'h0000_0042);
    @(negedge clk);

    // sop arriving inside a packet
    beat(1'b1, 1'b0, {1'b0, 12'd0, 4'd9, 8'd6, 3'd2, 4'd0});
    beat(1'b0, 1'b0, {4'd9, 12'd0, 16'd0});
    beat(1'b0, 1'b0, {4'd9, 12'd0, 16'd1});
    beat(1'b1, 1'b0, {1'b0, 12'd0, 4'd10, 8'd2, 3'd1, 4'd0});
    beat(1'b0, 1'b0, 32'h0);
    expect_pkt(1'b0, 3'd5, 4'd9, 3'd2, 8'd6, 1'b1);
    beat(1'b0, 1'b1, 32'h0);
    @(negedge clk);

    // reset in the middle of a packet, then a fresh src 0 seq 0 packet
    beat(1'b1, 1'b0, {1'b0, 12'd3, 4'd0, 8'd8, 3'd1, 4'd0});
    beat(1'b0, 1'b0, {4'd0, 12'd3, 16'd0});
    beat(1'b0, 1'b0, {4'd0, 12'd3, 16'd1});
    rst = 1'b1;
    #1;
    chk("midrst_pkt_cnt", pkt_cnt, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_err_code", err_code, 0);
    chk("midrst_last_len", last_len, 0);
    q.delete();
    m_pc = '0; m_ec = '0; m_code = '0; m_src = '0; m_prio = '0; m_len = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_pkt('{4'd0, 4'd0, 3'd3, 8'd5, 12'd0, 5, -1, 0, 3'd0});
    chk("post_rst_pkt_cnt", pkt_cnt, 1);
    chk("post_rst_err_cnt", err_cnt, 0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
